// File: rtl/mux8_scan_sequencer.sv
// Scan sequencer for a shared 8:1 single-bit mux: walks the enabled channels in
// ascending order, holds select/strobe for SETTLE cycles, samples, and publishes an 8-bit word.
module mux8_scan_sequencer #(
  parameter int SETTLE     = 2,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] ch_mask,
  input  logic       mux_in,
  output logic [2:0] mux_sel,
  output logic       mux_strobe_n,
  output logic       busy,
  output logic       done,
  output logic [7:0] scan_word
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t     state_reg, state_next;
  logic [2:0] ch_reg, ch_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [7:0] mask_reg, mask_next;
  logic [7:0] shadow_reg, shadow_next;
  logic [7:0] word_reg, word_next;
  logic       stop_reg, stop_next;

  logic [7:0] above_ch;
  logic [7:0] cand;
  logic [2:0] pick_ch;
  logic       has_next;

  // above_ch[i] is set for every channel strictly above the current one (no wrap)
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_above
      assign above_ch[gi] = (ch_reg < 3'(gi));
    end
  endgenerate

  // LOAD picks the lowest enabled channel; SAMPLE picks the next one above ch_reg
  always_comb begin
    cand     = (state_reg == S_LOAD) ? mask_reg : (mask_reg & above_ch);
    pick_ch  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (cand[i]) pick_ch = 3'(i);
    end
    has_next = |cand;
  end

  always_comb begin
    state_next  = state_reg;
    ch_next     = ch_reg;
    cnt_next    = cnt_reg;
    mask_next   = mask_reg;
    shadow_next = shadow_reg;
    word_next   = word_reg;
    stop_next   = stop_reg | (CONTINUOUS && stop);

    case (state_reg)
      S_IDLE: begin
        stop_next = CONTINUOUS && start && stop;
        if (start) begin
          mask_next   = ch_mask;
          shadow_next = 8'h00;
          state_next  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (has_next) begin
          ch_next    = pick_ch;
          cnt_next   = SETTLE_LOAD;
          state_next = S_SETTLE;
        end else begin
          state_next = S_DONE;
        end
      end
      S_SETTLE: begin
        if (cnt_reg == 4'd0) state_next = S_SAMPLE;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      S_SAMPLE: begin
        shadow_next[ch_reg] = mux_in;
        if (has_next) begin
          ch_next    = pick_ch;
          cnt_next   = SETTLE_LOAD;
          state_next = S_SETTLE;
        end else begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        word_next = shadow_reg;
        if (CONTINUOUS && !stop_next) begin
          mask_next   = ch_mask;
          shadow_next = 8'h00;
          state_next  = S_LOAD;
        end else begin
          stop_next  = 1'b0;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      ch_reg     <= 3'd0;
      cnt_reg    <= 4'd0;
      mask_reg   <= 8'h00;
      shadow_reg <= 8'h00;
      word_reg   <= 8'h00;
      stop_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ch_reg     <= ch_next;
      cnt_reg    <= cnt_next;
      mask_reg   <= mask_next;
      shadow_reg <= shadow_next;
      word_reg   <= word_next;
      stop_reg   <= stop_next;
    end
  end

  assign mux_sel      = ch_reg;
  assign mux_strobe_n = !((state_reg == S_SETTLE) || (state_reg == S_SAMPLE));
  assign busy         = (state_reg != S_IDLE);
  assign done         = (state_reg == S_DONE);
  assign scan_word    = word_reg;

endmodule

// File: tb/tb_mux8_scan_sequencer.sv
// Bench for mux8_scan_sequencer: one single-pass and one continuous instance,
// expected done timing/word queued by the stimulus and checked by per-instance monitors.
module tb_mux8_scan_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] word;
    int         cyc;
    logic       busy_after;
  } exp_t;

  exp_t q_a[$];
  exp_t q_c[$];

  // single-pass instance
  logic       start_a = 1'b0, stop_a = 1'b0;
  logic [7:0] mask_a = 8'h00, data_a = 8'h00;
  logic       mux_in_a, strobe_a, busy_a, done_a;
  logic [2:0] sel_a;
  logic [7:0] word_a;

  // continuous instance
  logic       start_c = 1'b0, stop_c = 1'b0;
  logic [7:0] mask_c = 8'h00, data_c = 8'h00;
  logic       mux_in_c, strobe_c, busy_c, done_c;
  logic [2:0] sel_c;
  logic [7:0] word_c;

  assign mux_in_a = data_a[sel_a] & ~strobe_a;
  assign mux_in_c = data_c[sel_c] & ~strobe_c;

  mux8_scan_sequencer #(.SETTLE(2), .CONTINUOUS(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .ch_mask(mask_a),
    .mux_in(mux_in_a), .mux_sel(sel_a), .mux_strobe_n(strobe_a),
    .busy(busy_a), .done(done_a), .scan_word(word_a)
  );

  mux8_scan_sequencer #(.SETTLE(2), .CONTINUOUS(1'b1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .stop(stop_c), .ch_mask(mask_c),
    .mux_in(mux_in_c), .mux_sel(sel_c), .mux_strobe_n(strobe_c),
    .busy(busy_c), .done(done_c), .scan_word(word_c)
  );

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end else begin
      $display("ok   %s: 0x%0h (cycle %0d)", name, actual, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  // monitor for the single-pass instance
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done_a === 1'b1) begin
        if (q_a.size() == 0) begin
          check("a_unexpected_done", 1, 0);
        end else begin
          e = q_a.pop_front();
          check("a_done_cycle", cyc, e.cyc);
          @(negedge clk);
          check("a_scan_word", int'(word_a), int'(e.word));
          check("a_busy_after_done", int'(busy_a), int'(e.busy_after));
        end
      end
    end
  end

  // monitor for the continuous instance
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done_c === 1'b1) begin
        if (q_c.size() == 0) begin
          check("c_unexpected_done", 1, 0);
        end else begin
          e = q_c.pop_front();
          check("c_done_cycle", cyc, e.cyc);
          @(negedge clk);
          check("c_scan_word", int'(word_c), int'(e.word));
          check("c_busy_after_done", int'(busy_c), int'(e.busy_after));
        end
      end
    end
  end

  initial begin
    int k;
    // 1: reset then idle
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    repeat (5) step();
    check("rst_strobe_n", int'(strobe_a), 1);
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_word", int'(word_a), 8'h00);
    check("rst_sel", int'(sel_a), 0);
    check("rst_c_strobe_n", int'(strobe_c), 1);
    check("rst_c_busy", int'(busy_c), 0);

    // 2: full mask, data 0xA5, sel 0..7 three cycles each
    data_a = 8'hA5; mask_a = 8'hFF; start_a = 1'b1;
    step(); k = cyc; start_a = 1'b0;
    q_a.push_back('{word: 8'hA5, cyc: k + 25, busy_after: 1'b0});
    for (int c = 1; c <= 24; c++) begin
      step();
      check("t2_sel", int'(sel_a), (c - 1) / 3);
      check("t2_strobe_n", int'(strobe_a), 0);
    end
    wait_until(k + 30);

    // 4: empty mask, done next cycle, strobe stays high
    mask_a = 8'h00; start_a = 1'b1;
    step(); k = cyc; start_a = 1'b0;
    q_a.push_back('{word: 8'h00, cyc: k + 1, busy_after: 1'b0});
    for (int c = 1; c <= 3; c++) begin
      step();
      check("t4_strobe_n", int'(strobe_a), 1);
    end
    wait_until(k + 6);

    // 3: sparse mask 0x81, only channels 0 and 7
    data_a = 8'hFF; mask_a = 8'h81; start_a = 1'b1;
    step(); k = cyc; start_a = 1'b0;
    q_a.push_back('{word: 8'h81, cyc: k + 7, busy_after: 1'b0});
    for (int c = 1; c <= 6; c++) begin
      step();
      check("t3_sel", int'(sel_a), (c <= 3) ? 0 : 7);
    end
    wait_until(k + 12);

    // 5: start while busy is ignored, reset mid-pass aborts, rescan afterwards
    data_a = 8'h3C; mask_a = 8'hFF; start_a = 1'b1;
    step(); k = cyc; start_a = 1'b0;
    wait_until(k + 5);
    mask_a = 8'h01; start_a = 1'b1;
    step(); start_a = 1'b0;
    check("t5_still_scanning_sel", int'(sel_a), 1);
    wait_until(k + 10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_rst_strobe_n", int'(strobe_a), 1);
    check("t5_rst_busy", int'(busy_a), 0);
    check("t5_rst_done", int'(done_a), 0);
    check("t5_rst_sel", int'(sel_a), 0);
    check("t5_rst_word", int'(word_a), 8'h00);
    step();
    mask_a = 8'hF0; start_a = 1'b1;
    step(); k = cyc; start_a = 1'b0;
    q_a.push_back('{word: 8'h30, cyc: k + 13, busy_after: 1'b0});
    wait_until(k + 20);

    // 6: continuous mode, data changes between passes, stop ends after current pass
    data_c = 8'h0A; mask_c = 8'h0F; start_c = 1'b1;
    step(); k = cyc; start_c = 1'b0;
    q_c.push_back('{word: 8'h0A, cyc: k + 13, busy_after: 1'b1});
    q_c.push_back('{word: 8'h05, cyc: k + 27, busy_after: 1'b1});
    q_c.push_back('{word: 8'h0C, cyc: k + 41, busy_after: 1'b0});
    wait_until(k + 13);
    data_c = 8'h05;
    wait_until(k + 27);
    data_c = 8'h0C;
    wait_until(k + 20 + 10);
    stop_c = 1'b1;
    step();
    stop_c = 1'b0;
    check("t6_busy_mid_pass", int'(busy_c), 1);
    wait_until(k + 80);
    check("t6_idle_after_stop", int'(busy_c), 0);

    check("queue_a_drained", q_a.size(), 0);
    check("queue_c_drained", q_c.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
